// File: rtl/fp_add_axis.sv
// AXI-Stream wrapped binary32 adder: loads A then B, waits for start, and
// returns A+B (round-to-nearest-even) as a single beat with tlast set.
module fp_add_axis #(
  parameter int SIZE       = 2,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    s00_axi_aclk,
  input  logic                    s00_axi_areset,
  output logic                    s00_axis_tready,
  input  logic [DATA_WIDTH-1:0]   s00_axis_tdata,
  input  logic                    s00_axis_tlast,
  input  logic                    s00_axis_tvalid,
  output logic                    m00_axis_tvalid,
  output logic [DATA_WIDTH-1:0]   m00_axis_tdata,
  output logic [DATA_WIDTH/8-1:0] m00_axis_tstrb,
  output logic                    m00_axis_tlast,
  input  logic                    m00_axis_tready,
  input  logic                    start,
  output logic [2:0]              dbg_state_o
);

  typedef enum logic [2:0] {
    LOAD       = 3'd0,
    WAIT_START = 3'd1,
    ALIGN      = 3'd2,
    ADD        = 3'd3,
    NORM       = 3'd4,
    ROUND      = 3'd5,
    OUTPUT     = 3'd6
  } state_t;

  state_t      state_q;
  logic [1:0]  count_q;
  logic [31:0] slot0_q, slot1_q;
  logic        tready_q, tvalid_q, tlast_q;
  logic [31:0] tdata_q;

  logic        spec_q, spec_d;
  logic [31:0] spec_val_q, spec_val_d;
  logic        sign_q, sign_d, sub_q, sub_d;
  logic [9:0]  exp_q, exp_d;
  logic [26:0] big_q, big_d, small_q, small_d;
  logic [27:0] sum_q, sum_d;
  logic [26:0] mant_q, mant_d;
  logic [9:0]  nexp_q, nexp_d;
  logic        zero_q, zero_d;
  logic [31:0] res_d;

  logic        a_zero, a_inf, a_nan, b_zero, b_inf, b_nan, swap;
  logic [30:0] a_mag, b_mag, big_mag, small_mag;
  logic [26:0] small_m;
  logic [7:0]  diff;
  logic [4:0]  lz;
  logic        rnd_up;
  logic [24:0] m25;
  logic [9:0]  rexp;
  logic [22:0] frac;
  logic        unused_tlast;

  assign unused_tlast    = s00_axis_tlast;
  assign s00_axis_tready = tready_q;
  assign m00_axis_tvalid = tvalid_q;
  assign m00_axis_tlast  = tlast_q;
  assign m00_axis_tdata  = tdata_q;
  assign m00_axis_tstrb  = '1;
  assign dbg_state_o     = state_q;

  // Align: unpack with hidden bit + GRS, flush subnormals, order by magnitude.
  always_comb begin
    a_zero    = (slot0_q[30:23] == 8'd0);
    b_zero    = (slot1_q[30:23] == 8'd0);
    a_inf     = (slot0_q[30:23] == 8'hFF) && (slot0_q[22:0] == 23'd0);
    b_inf     = (slot1_q[30:23] == 8'hFF) && (slot1_q[22:0] == 23'd0);
    a_nan     = (slot0_q[30:23] == 8'hFF) && (slot0_q[22:0] != 23'd0);
    b_nan     = (slot1_q[30:23] == 8'hFF) && (slot1_q[22:0] != 23'd0);
    a_mag     = a_zero ? 31'd0 : slot0_q[30:0];
    b_mag     = b_zero ? 31'd0 : slot1_q[30:0];
    swap      = (b_mag > a_mag);
    big_mag   = swap ? b_mag : a_mag;
    small_mag = swap ? a_mag : b_mag;
    big_d     = (big_mag == 31'd0) ? 27'd0 : {1'b1, big_mag[22:0], 3'b000};
    small_m   = (small_mag == 31'd0) ? 27'd0 : {1'b1, small_mag[22:0], 3'b000};
    diff      = big_mag[30:23] - small_mag[30:23];
    if (diff >= 8'd26) begin
      small_d = {26'd0, |small_m};
    end else begin
      small_d    = small_m >> diff;
      small_d[0] = small_d[0] | (|(small_m & ((27'd1 << diff) - 27'd1)));
    end
    sign_d     = swap ? slot1_q[31] : slot0_q[31];
    sub_d      = slot0_q[31] ^ slot1_q[31];
    exp_d      = {2'b00, big_mag[30:23]};
    spec_d     = 1'b1;
    spec_val_d = 32'd0;
    if (a_nan || b_nan || (a_inf && b_inf && (slot0_q[31] != slot1_q[31]))) begin
      spec_val_d = 32'h7FC00000;
    end else if (a_inf) begin
      spec_val_d = slot0_q;
    end else if (b_inf) begin
      spec_val_d = slot1_q;
    end else if (a_zero && b_zero) begin
      spec_val_d = {slot0_q[31] & slot1_q[31], 31'd0};
    end else begin
      spec_d = 1'b0;
    end
  end

  always_comb begin
    sum_d = sub_q ? ({1'b0, big_q} - {1'b0, small_q}) : ({1'b0, big_q} + {1'b0, small_q});
  end

  always_comb begin
    zero_d = (sum_q == 28'd0);
    lz     = 5'd0;
    for (int i = 0; i < 27; i++) begin
      if (sum_q[i]) lz = 5'(26 - i);
    end
    if (sum_q[27]) begin
      mant_d = {sum_q[27:2], sum_q[1] | sum_q[0]};
      nexp_d = exp_q + 10'd1;
    end else begin
      mant_d = sum_q[26:0] << lz;
      nexp_d = exp_q - {5'd0, lz};
    end
  end

  // Round to nearest even; a carry out of the mantissa bumps the exponent.
  always_comb begin
    rnd_up = mant_q[2] & (mant_q[1] | mant_q[0] | mant_q[3]);
    m25    = {1'b0, mant_q[26:3]} + {24'd0, rnd_up};
    rexp   = m25[24] ? nexp_q + 10'd1 : nexp_q;
    frac   = m25[24] ? m25[23:1] : m25[22:0];
    if (spec_q)                          res_d = spec_val_q;
    else if (zero_q)                     res_d = 32'd0;
    else if ($signed(rexp) <= 10'sd0)    res_d = {sign_q, 31'd0};
    else if ($signed(rexp) >= 10'sd255)  res_d = {sign_q, 8'hFF, 23'd0};
    else                                 res_d = {sign_q, rexp[7:0], frac};
  end

  // Slave beats transfer on tvalid && tready at a rising edge; the master
  // beat is held unchanged from tvalid rising until tvalid && tready.
  always_ff @(posedge s00_axi_aclk) begin
    if (s00_axi_areset) begin
      state_q    <= LOAD;
      count_q    <= 2'd0;
      slot0_q    <= 32'd0;
      slot1_q    <= 32'd0;
      tready_q   <= 1'b0;
      tvalid_q   <= 1'b0;
      tlast_q    <= 1'b0;
      tdata_q    <= 32'd0;
      spec_q     <= 1'b0;
      spec_val_q <= 32'd0;
      sign_q     <= 1'b0;
      sub_q      <= 1'b0;
      exp_q      <= 10'd0;
      big_q      <= 27'd0;
      small_q    <= 27'd0;
      sum_q      <= 28'd0;
      mant_q     <= 27'd0;
      nexp_q     <= 10'd0;
      zero_q     <= 1'b0;
    end else begin
      case (state_q)
        LOAD: begin
          tready_q <= 1'b1;
          if (s00_axis_tvalid && tready_q) begin
            if (count_q == 2'd0) slot0_q <= s00_axis_tdata;
            else                 slot1_q <= s00_axis_tdata;
            if (count_q == 2'(SIZE - 1)) begin
              count_q  <= 2'(SIZE);
              tready_q <= 1'b0;
              state_q  <= WAIT_START;
            end else begin
              count_q <= count_q + 2'd1;
            end
          end
        end
        WAIT_START: begin
          if (start) state_q <= ALIGN;
        end
        ALIGN: begin
          spec_q     <= spec_d;
          spec_val_q <= spec_val_d;
          sign_q     <= sign_d;
          sub_q      <= sub_d;
          exp_q      <= exp_d;
          big_q      <= big_d;
          small_q    <= small_d;
          state_q    <= ADD;
        end
        ADD: begin
          sum_q   <= sum_d;
          state_q <= NORM;
        end
        NORM: begin
          mant_q  <= mant_d;
          nexp_q  <= nexp_d;
          zero_q  <= zero_d;
          state_q <= ROUND;
        end
        ROUND: begin
          tdata_q  <= res_d;
          tvalid_q <= 1'b1;
          tlast_q  <= 1'b1;
          state_q  <= OUTPUT;
        end
        OUTPUT: begin
          if (m00_axis_tready) begin
            tvalid_q <= 1'b0;
            tlast_q  <= 1'b0;
            count_q  <= 2'd0;
            state_q  <= LOAD;
          end
        end
        default: state_q <= LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_add_axis.sv
// Bench for fp_add_axis: directed vectors, handshake corner cases and random
// integer-valued sums, checked through an expected-result queue.
module tb_fp_add_axis;

  logic        clk = 1'b0;
  logic        rst;
  logic        s_tready, s_tlast, s_tvalid;
  logic [31:0] s_tdata;
  logic        m_tvalid, m_tlast, m_tready;
  logic [31:0] m_tdata;
  logic [3:0]  m_tstrb;
  logic        start;
  logic [2:0]  dbg_state;

  always #5 clk = ~clk;

  fp_add_axis dut (
    .s00_axi_aclk    (clk),
    .s00_axi_areset  (rst),
    .s00_axis_tready (s_tready),
    .s00_axis_tdata  (s_tdata),
    .s00_axis_tlast  (s_tlast),
    .s00_axis_tvalid (s_tvalid),
    .m00_axis_tvalid (m_tvalid),
    .m00_axis_tdata  (m_tdata),
    .m00_axis_tstrb  (m_tstrb),
    .m00_axis_tlast  (m_tlast),
    .m00_axis_tready (m_tready),
    .start           (start),
    .dbg_state_o     (dbg_state)
  );

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [31:0] exp_q[$];
  string       cur_tag  = "reset";

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] int_to_f(input int v);
    int          m, msb;
    logic [31:0] t;
    if (v == 0) return 32'd0;
    m   = (v < 0) ? -v : v;
    msb = 0;
    for (int i = 0; i < 31; i++) if (m[i]) msb = i;
    t = 32'(m) << (23 - msb);
    return {v < 0, 8'(127 + msb), t[22:0]};
  endfunction

  // Output side of the scoreboard: pop on every accepted result beat.
  always @(negedge clk) begin
    if (m_tvalid && m_tready) begin
      if (exp_q.size() == 0) begin
        check({cur_tag, "_spurious_out"}, 32'(m_tvalid), 32'd0);
      end else begin
        check({cur_tag, "_result"}, m_tdata, exp_q.pop_front());
        check({cur_tag, "_tlast"}, 32'(m_tlast), 32'd1);
      end
    end
  end

  task automatic send_beat(input logic [31:0] d, input logic last);
    int n;
    n        = 0;
    s_tdata  = d;
    s_tlast  = last;
    s_tvalid = 1'b1;
    while (!s_tready && n < 50) begin
      tick();
      n++;
    end
    if (!s_tready) check({cur_tag, "_load_timeout"}, 32'(s_tready), 32'd1);
    tick();
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  task automatic fire(input logic [31:0] e, input int hold);
    int          stable;
    logic [31:0] d0;
    exp_q.push_back(e);
    m_tready = (hold == 0);
    start    = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) tick();
    check({cur_tag, "_lat_early"}, 32'(m_tvalid), 32'd0);
    tick();
    check({cur_tag, "_lat"}, 32'(m_tvalid), 32'd1);
    if (hold > 0) begin
      d0     = m_tdata;
      stable = 0;
      for (int i = 0; i < hold; i++) begin
        tick();
        if (m_tvalid && m_tlast && m_tdata == d0) stable++;
      end
      check({cur_tag, "_hold_stable"}, 32'(stable), 32'(hold));
      m_tready = 1'b1;
    end
    tick();
    check({cur_tag, "_valid_clear"}, 32'(m_tvalid), 32'd0);
  endtask

  task automatic run_pair(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] e);
    cur_tag = tag;
    send_beat(a, 1'b0);
    send_beat(b, 1'b1);
    fire(e, 0);
  endtask

  localparam int NV = 17;
  logic [31:0] va[NV] = '{32'h00000000, 32'h40490FDB, 32'h42F6E979, 32'hC2F6E979,
                          32'h42F6E979, 32'hC2F6E979, 32'h42C80000, 32'h7F800000,
                          32'h7F7FFFFF, 32'h80000000, 32'h7FC00001, 32'h7F800000,
                          32'hFF800000, 32'h00000001, 32'h3F800000, 32'h3F800001,
                          32'h00800000};
  logic [31:0] vb[NV] = '{32'h00000000, 32'hC0490FDB, 32'h42DE38D5, 32'h42DE38D5,
                          32'hC2DE38D5, 32'hC2DE38D5, 32'hBA83126F, 32'hFF800000,
                          32'h7F7FFFFF, 32'h80000000, 32'h3F800000, 32'h3F800000,
                          32'hC0000000, 32'h3F800000, 32'h33800000, 32'h33800000,
                          32'h80800001};
  logic [31:0] ve[NV] = '{32'h00000000, 32'h00000000, 32'h436A9127, 32'hC1458520,
                          32'h41458520, 32'hC36A9127, 32'h42C7FF7D, 32'h7FC00000,
                          32'h7F800000, 32'h80000000, 32'h7FC00000, 32'h7F800000,
                          32'hFF800000, 32'h3F800000, 32'h3F800000, 32'h3F800002,
                          32'h80000000};

  initial begin
    rst      = 1'b1;
    s_tvalid = 1'b0;
    s_tdata  = 32'd0;
    s_tlast  = 1'b0;
    m_tready = 1'b1;
    start    = 1'b0;
    repeat (3) tick();
    check("rst_tready", 32'(s_tready), 32'd0);
    check("rst_tvalid", 32'(m_tvalid), 32'd0);
    check("rst_tlast", 32'(m_tlast), 32'd0);
    check("rst_tdata", m_tdata, 32'd0);
    check("rst_tstrb", 32'(m_tstrb), 32'hF);
    rst = 1'b0;

    for (int k = 0; k < NV; k++) run_pair($sformatf("vec%0d", k), va[k], vb[k], ve[k]);

    // A third beat offered after the pair must stay on the bus untaken.
    cur_tag = "third_beat";
    send_beat(32'h3F800000, 1'b0);
    send_beat(32'h40000000, 1'b1);
    check("tready_drop", 32'(s_tready), 32'd0);
    s_tvalid = 1'b1;
    s_tdata  = 32'h3F800000;
    repeat (3) begin
      tick();
      check("third_not_taken", 32'(s_tready), 32'd0);
    end
    s_tvalid = 1'b0;
    fire(32'h40400000, 0);
    run_pair("after_third", 32'h40000000, 32'h40000000, 32'h40800000);

    cur_tag = "early_start";
    send_beat(32'h3F800000, 1'b0);
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (8) tick();
    check("early_start_ignored", 32'(m_tvalid), 32'd0);
    send_beat(32'h40000000, 1'b1);
    fire(32'h40400000, 0);

    cur_tag = "backpressure";
    send_beat(32'h42F6E979, 1'b0);
    send_beat(32'h42DE38D5, 1'b1);
    fire(32'h436A9127, 10);
    run_pair("after_bp", 32'h40400000, 32'h40800000, 32'h40E00000);

    cur_tag = "rst_align";
    send_beat(32'h40490FDB, 1'b0);
    send_beat(32'h40490FDB, 1'b1);
    start = 1'b1;
    tick();
    start = 1'b0;
    rst   = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_align_tvalid", 32'(m_tvalid), 32'd0);
    check("rst_align_tready", 32'(s_tready), 32'd0);
    check("rst_align_tlast", 32'(m_tlast), 32'd0);
    check("rst_align_tdata", m_tdata, 32'd0);
    repeat (8) tick();
    check("rst_align_no_out", 32'(m_tvalid), 32'd0);
    run_pair("after_rst", 32'h3F800000, 32'hC0000000, 32'hBF800000);

    for (int k = 0; k < 8; k++) begin
      int ia, ib;
      ia = int'($urandom_range(2000)) - 1000;
      ib = int'($urandom_range(2000)) - 1000;
      run_pair($sformatf("rand%0d", k), int_to_f(ia), int_to_f(ib), int_to_f(ia + ib));
    end

    repeat (3) tick();
    check("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
